// File: rtl/mac_acc_sched_if.sv
// Operand-stream and result handshake bundle for mac_acc_sched.
// master = sequencer side, slave = source/datapath/sink side.
interface mac_acc_sched_if;

    // Operand stream from the source
    logic in_valid_i;
    logic in_ready_o;

    // Datapath control strobes
    logic mac_en_o;
    logic acc_clr_o;
    logic acc_last_o;

    // Result port toward the consumer
    logic res_valid_o;
    logic res_ready_i;

    modport master (
        input  in_valid_i,
        input  res_ready_i,
        output in_ready_o,
        output mac_en_o,
        output acc_clr_o,
        output acc_last_o,
        output res_valid_o
    );

    modport slave (
        output in_valid_i,
        output res_ready_i,
        input  in_ready_o,
        input  mac_en_o,
        input  acc_clr_o,
        input  acc_last_o,
        input  res_valid_o
    );

endinterface

// File: rtl/mac_acc_sched.sv
// Multiply-accumulate job sequencer: meters operands, frames windows,
// presents results and signals job completion.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start_i           job request (honoured only when idle)
//   cfg_len_i         products per accumulation (nonzero)
//   cfg_num_i         results per job (nonzero)
//   abort_i           synchronous job abort
//   busy_o            job in progress
//   cfg_err_o         one-cycle pulse on start with a zero config
//   bus               operand/result handshake bundle (master side)
//   done_o            one-cycle pulse after the last result is taken
//   irq_o             sticky completion interrupt
//   irq_clr_i         clears irq_o
module mac_acc_sched #(
    parameter int WIDTH_CNT = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [WIDTH_CNT-1:0] cfg_len_i,
    input  logic [WIDTH_CNT-1:0] cfg_num_i,
    input  logic                 abort_i,
    output logic                 busy_o,
    output logic                 cfg_err_o,
    mac_acc_sched_if.master      bus,
    output logic                 done_o,
    output logic                 irq_o,
    input  logic                 irq_clr_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [WIDTH_CNT-1:0] ONE = WIDTH_CNT'(1);

    state_t               state;
    logic [WIDTH_CNT-1:0] len_q;
    logic [WIDTH_CNT-1:0] num_q;
    logic [WIDTH_CNT-1:0] beat_cnt;
    logic [WIDTH_CNT-1:0] res_cnt;
    logic                 res_valid_q;
    logic                 cfg_err_q;
    logic                 done_q;
    logic                 irq_q;

    logic                 stall;
    logic                 in_ready;
    logic                 mac_en;
    logic                 beat_first;
    logic                 beat_last;
    logic                 res_hs;
    logic                 cfg_ok;
    logic [WIDTH_CNT-1:0] len_m1;
    logic [WIDTH_CNT-1:0] res_cnt_nxt;

    // len is never zero inside a job, so len-1 cannot underflow there.
    assign len_m1      = len_q - ONE;
    assign res_cnt_nxt = res_cnt + ONE;
    assign cfg_ok      = (cfg_len_i != '0) && (cfg_num_i != '0);

    assign stall    = res_valid_q && !bus.res_ready_i;
    assign res_hs   = res_valid_q && bus.res_ready_i;
    // An aborting cycle must not consume the presented beat.
    assign in_ready = (state == RUN) && !stall && !abort_i;
    assign mac_en   = in_ready && bus.in_valid_i;

    assign beat_first = (beat_cnt == '0);
    assign beat_last  = (beat_cnt == len_m1);

    assign bus.in_ready_o  = in_ready;
    assign bus.mac_en_o    = mac_en;
    assign bus.acc_clr_o   = mac_en && beat_first;
    assign bus.acc_last_o  = mac_en && beat_last;
    assign bus.res_valid_o = res_valid_q;

    assign busy_o    = (state != IDLE);
    assign cfg_err_o = cfg_err_q;
    assign done_o    = done_q;
    assign irq_o     = irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            len_q       <= '0;
            num_q       <= '0;
            beat_cnt    <= '0;
            res_cnt     <= '0;
            res_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            done_q      <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            cfg_err_q <= 1'b0;
            done_q    <= 1'b0;

            if (irq_clr_i) begin
                irq_q <= 1'b0;
            end

            // Ordering gives a new result priority over consumption.
            if (res_hs) begin
                res_valid_q <= 1'b0;
            end
            if (mac_en && beat_last) begin
                res_valid_q <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        if (cfg_ok) begin
                            len_q    <= cfg_len_i;
                            num_q    <= cfg_num_i;
                            beat_cnt <= '0;
                            res_cnt  <= '0;
                            state    <= RUN;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (abort_i) begin
                        beat_cnt    <= '0;
                        res_cnt     <= '0;
                        res_valid_q <= 1'b0;
                        state       <= IDLE;
                    end else if (mac_en) begin
                        if (beat_last) begin
                            beat_cnt <= '0;
                            res_cnt  <= res_cnt_nxt;
                            if (res_cnt_nxt == num_q) begin
                                state <= DRAIN;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + ONE;
                        end
                    end
                end

                DRAIN: begin
                    if (abort_i) begin
                        beat_cnt    <= '0;
                        res_cnt     <= '0;
                        res_valid_q <= 1'b0;
                        state       <= IDLE;
                    end else if (res_hs) begin
                        // Only the final result can be pending here.
                        res_cnt <= '0;
                        done_q  <= 1'b1;
                        irq_q   <= 1'b1;
                        state   <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mac_acc_sched.md
Name: mac_acc_sched

Overview:
- Sequencer for the multiply-accumulate datapath.
- Accepts a job: products per accumulation (len) and number of accumulation results (num).
- Meters the operand stream into the MAC, marks the first and last beat of each accumulation window, and presents each result on a valid/ready port.
- Raises done and a sticky interrupt when the job completes.

Parameters:
- WIDTH_CNT, 5: width of the len/num configuration and of the internal beat and result counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  job request; accepted only in IDLE
- cfg_len_i  in  WIDTH_CNT  products per accumulation; 0 is illegal
- cfg_num_i  in  WIDTH_CNT  results per job; 0 is illegal
- abort_i  in  1  synchronous job abort
- busy_o  out  1  job in progress (state != IDLE)
- cfg_err_o  out  1  one-cycle pulse: start with illegal config
- in_valid_i  in  1  operand pair valid from source
- in_ready_o  out  1  controller accepts operand pair
- mac_en_o  out  1  datapath multiplies and accumulates this cycle
- acc_clr_o  out  1  with mac_en_o: load product into accumulator instead of adding
- acc_last_o  out  1  with mac_en_o: final beat; datapath copies the sum into its result register
- res_valid_o  out  1  result register holds an unconsumed result
- res_ready_i  in  1  downstream accepts result
- done_o  out  1  one-cycle pulse after the last result is accepted
- irq_o  out  1  sticky completion interrupt
- irq_clr_i  in  1  clears irq_o

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE; counters go to 0.
  - busy_o, cfg_err_o, in_ready_o, res_valid_o, done_o and irq_o are all 0.
  - mac_en_o, acc_clr_o and acc_last_o are 0 (combinational from zeroed state).
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start_i with both cfg values nonzero: latch len and num, clear beat_cnt and res_cnt, go to RUN.
  - start_i with either cfg value zero: stay in IDLE; cfg_err_o pulses on the next cycle.
  - start_i outside IDLE is ignored.
- Stall condition: stall = res_valid_o && !res_ready_i.
- RUN handshake:
  - in_ready_o = (state==RUN) && !stall.
  - A beat is accepted when in_valid_i && in_ready_o.
  - mac_en_o = accepted beat (combinational).
  - acc_clr_o = mac_en_o && beat_cnt==0.
  - acc_last_o = mac_en_o && beat_cnt==len-1.
  - When len==1, acc_clr_o and acc_last_o assert together.
- Beat counter:
  - Increments on each accepted beat.
  - Wraps to 0 on the last beat.
  - No arithmetic overflow: compare against len-1 at WIDTH_CNT bits. len=2^W-1 is the maximum.
- Result presentation:
  - res_valid_o sets on the clock edge after an acc_last_o beat (latency 1).
  - It clears on res_valid_o && res_ready_i.
  - Set and clear in the same cycle: set wins. Back-to-back results are possible when len==1 and res_ready_i is held high.
- Result counter:
  - res_cnt increments on each acc_last_o beat.
  - When the incremented value equals num, go to DRAIN. No further beats are accepted (in_ready_o=0).
- DRAIN:
  - When the final result handshakes, go to IDLE, pulse done_o for one cycle and set irq_o.
  - res_ready_i held low keeps the block in DRAIN indefinitely.
- irq_o:
  - Set on done and held until irq_clr_i.
  - Set and irq_clr_i in the same cycle: set wins.
  - irq_clr_i in IDLE with irq_o=0 has no effect.
- abort_i (RUN or DRAIN):
  - Next state is IDLE; counters clear; res_valid_o drops.
  - No done_o pulse, no irq_o.
  - The beat presented in the abort cycle is not accepted (in_ready_o forced 0 when abort_i=1).
  - abort_i in IDLE is ignored.
- Reset mid-job: all state discarded immediately. The datapath accumulator content is don't-care because the next job's first beat asserts acc_clr_o.

Test Plan:
- len=31, num=2, in_valid_i=1, res_ready_i=1:
  - Beats 1 and 32 carry acc_clr_o; beats 31 and 62 carry acc_last_o.
  - res_valid_o is high the cycle after each acc_last_o beat.
  - done_o pulses and irq_o sets one cycle after the second result (cycle 63 after start); exactly 62 mac_en_o.
- len=4, num=3, res_ready_i low after first result:
  - in_ready_o drops once res_valid_o is stalled and the second window's last beat is done (the 8th mac_en_o).
  - Raising res_ready_i resumes the stream with zero lost or duplicated beats; total 12 mac_en_o.
- len=1, num=5, res_ready_i=1, continuous valid:
  - Every beat has acc_clr_o=acc_last_o=1; 5 results accepted on consecutive cycles.
  - done_o appears after the 5th.
- start_i with cfg_len_i=0 (then cfg_num_i=0): cfg_err_o pulses once each, busy_o stays 0.
  - start_i while busy is ignored; cfg is unchanged.
- abort_i at beat 10 of len=31:
  - Next cycle IDLE, busy_o=0, res_valid_o=0, no done_o/irq_o.
  - A fresh job then starts cleanly with acc_clr_o on its first beat.
- irq_clr_i asserted in the same cycle as completion: irq_o=1 afterwards; a subsequent irq_clr_i clears it.
  - rst_n low mid-RUN clears all outputs asynchronously.
